// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline-side and memory-side signals of the MEM-stage
// load/store sequencer, bundled so the sequencer and its environment share one
// definition. Opcode and data-width macros are provided here when no
// surrounding core has defined them.
//
// Handshake summary:
//   Pipeline side: an access is taken in an IDLE cycle where lsu_i_valid is
//   high with a memory opcode; lsu_o_stall (combinational) tells the pipeline
//   to hold the instruction; lsu_o_done pulses for exactly one cycle when the
//   access retires, with lsu_o_err and lsu_o_rdata valid in that cycle.
//   Memory side: lsu_o_mem_req is held high with lsu_o_mem_we, lsu_o_mem_addr
//   and lsu_o_mem_wdata stable until a cycle in which lsu_i_mem_ack is high;
//   lsu_i_mem_rdata is only looked at in that cycle. Ack without req is ignored.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef LOAD
`define LOAD               4'd1
`define LOAD_BYTE          4'd2
`define LOAD_HALF          4'd3
`define LOAD_BYTE_UNSIGNED 4'd4
`define LOAD_HALF_UNSIGNED 4'd5
`define STORE              4'd6
`define STORE_BYTE         4'd7
`define STORE_HALF         4'd8
`endif

interface mem_access_ctrl_if #(
  parameter int AWIDTH = 32
);
  logic                     lsu_i_valid;
  logic [`OPCODE_WIDTH-1:0] lsu_i_opcode;
  logic [AWIDTH-1:0]        lsu_i_addr;
  logic [`DWIDTH-1:0]       lsu_i_wdata;
  logic                     lsu_o_stall;
  logic                     lsu_o_done;
  logic [`DWIDTH-1:0]       lsu_o_rdata;
  logic                     lsu_o_err;
  logic                     lsu_o_mem_req;
  logic                     lsu_o_mem_we;
  logic [AWIDTH-1:0]        lsu_o_mem_addr;
  logic [`DWIDTH-1:0]       lsu_o_mem_wdata;
  logic                     lsu_i_mem_ack;
  logic [`DWIDTH-1:0]       lsu_i_mem_rdata;
  // Debug view of the sequencer state (IDLE=0 READ=1 WRITE=2 RMW_RD=3 RMW_WR=4 DONE=5)
  logic [2:0]               lsu_o_dbg_state;

  // Environment: pipeline plus data memory
  modport master (
    output lsu_i_valid, lsu_i_opcode, lsu_i_addr, lsu_i_wdata,
    output lsu_i_mem_ack, lsu_i_mem_rdata,
    input  lsu_o_stall, lsu_o_done, lsu_o_rdata, lsu_o_err,
    input  lsu_o_mem_req, lsu_o_mem_we, lsu_o_mem_addr, lsu_o_mem_wdata,
    input  lsu_o_dbg_state
  );

  // The sequencer itself
  modport slave (
    input  lsu_i_valid, lsu_i_opcode, lsu_i_addr, lsu_i_wdata,
    input  lsu_i_mem_ack, lsu_i_mem_rdata,
    output lsu_o_stall, lsu_o_done, lsu_o_rdata, lsu_o_err,
    output lsu_o_mem_req, lsu_o_mem_we, lsu_o_mem_addr, lsu_o_mem_wdata,
    output lsu_o_dbg_state
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle data-memory access sequencer for the MEM stage.
// One load/store at a time; word-addressed req/ack memory; byte/half stores
// are done as read-modify-write; load data is returned lane-shifted and
// sign/zero-extended. Little-endian lanes, data path fixed at 32 bits.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN -- when defined,
// misaligned half/word accesses skip memory and retire with err=1.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef LOAD
`define LOAD               4'd1
`define LOAD_BYTE          4'd2
`define LOAD_HALF          4'd3
`define LOAD_BYTE_UNSIGNED 4'd4
`define LOAD_HALF_UNSIGNED 4'd5
`define STORE              4'd6
`define STORE_BYTE         4'd7
`define STORE_HALF         4'd8
`endif

module mem_access_ctrl #(
  parameter int AWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              lsu_i_clk,
  input  logic              lsu_i_rst,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                   state_q;
  logic [`OPCODE_WIDTH-1:0] op_q;
  logic [1:0]               lane_q;
  logic [`DWIDTH-1:0]       store_q;
  logic [`DWIDTH-1:0]       mem_wdata_q;
  logic [`DWIDTH-1:0]       rdata_q;
  logic [AWIDTH-1:0]        mem_addr_q;
  logic                     req_q;
  logic                     we_q;
  logic                     done_q;
  logic                     err_q;
  logic [31:0]              tmo_q;
  logic                     tmo_hit;
  logic                     trap;
  logic                     accept;

  function automatic logic is_load(input logic [`OPCODE_WIDTH-1:0] op);
    return (op == `LOAD) || (op == `LOAD_BYTE) || (op == `LOAD_HALF) ||
           (op == `LOAD_BYTE_UNSIGNED) || (op == `LOAD_HALF_UNSIGNED);
  endfunction

  function automatic logic is_mem(input logic [`OPCODE_WIDTH-1:0] op);
    return is_load(op) || (op == `STORE) || (op == `STORE_BYTE) || (op == `STORE_HALF);
  endfunction

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [`DWIDTH-1:0] load_extend(input logic [`OPCODE_WIDTH-1:0] op,
                                                     input logic [1:0] lane,
                                                     input logic [`DWIDTH-1:0] word);
    logic [7:0]         b;
    logic [15:0]        h;
    logic [`DWIDTH-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (op)
      `LOAD_BYTE:          r = {{24{b[7]}}, b};
      `LOAD_BYTE_UNSIGNED: r = {24'd0, b};
      `LOAD_HALF:          r = {{16{h[15]}}, h};
      `LOAD_HALF_UNSIGNED: r = {16'd0, h};
      default:             r = word;
    endcase
    return r;
  endfunction

  // Insert the low byte/half of the store data into the word read back.
  function automatic logic [`DWIDTH-1:0] store_merge(input logic [`OPCODE_WIDTH-1:0] op,
                                                     input logic [1:0] lane,
                                                     input logic [`DWIDTH-1:0] word,
                                                     input logic [`DWIDTH-1:0] data);
    logic [`DWIDTH-1:0] r;
    r = word;
    if (op == `STORE_BYTE) r[{lane, 3'b000} +: 8] = data[7:0];
    else                   r[{lane[1], 4'b0000} +: 16] = data[15:0];
    return r;
  endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [`OPCODE_WIDTH-1:0] op, input logic [1:0] a);
    logic half_op;
    logic word_op;
    half_op = (op == `LOAD_HALF) || (op == `LOAD_HALF_UNSIGNED) || (op == `STORE_HALF);
    word_op = (op == `LOAD) || (op == `STORE);
    return (half_op && a[0]) || (word_op && (a != 2'b00));
  endfunction
  // Misaligned accesses bypass memory entirely
  assign trap = misaligned(bus.lsu_i_opcode, bus.lsu_i_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign accept  = bus.lsu_i_valid && is_mem(bus.lsu_i_opcode);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  // Stall: a new access is being taken, or one is waiting on memory
  assign bus.lsu_o_stall = ((state_q == S_IDLE) && accept) ||
                           (state_q == S_READ)   || (state_q == S_WRITE) ||
                           (state_q == S_RMW_RD) || (state_q == S_RMW_WR);

  assign bus.lsu_o_done      = done_q;
  assign bus.lsu_o_err       = err_q;
  assign bus.lsu_o_rdata     = rdata_q;
  assign bus.lsu_o_mem_req   = req_q;
  assign bus.lsu_o_mem_we    = we_q;
  assign bus.lsu_o_mem_addr  = mem_addr_q;
  assign bus.lsu_o_mem_wdata = mem_wdata_q;
  assign bus.lsu_o_dbg_state = state_q;

  // Access sequencer: state, memory request and result registers
  always_ff @(posedge lsu_i_clk) begin
    if (lsu_i_rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      lane_q      <= '0;
      store_q     <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (accept) begin
            op_q       <= bus.lsu_i_opcode;
            lane_q     <= bus.lsu_i_addr[1:0];
            store_q    <= bus.lsu_i_wdata;
            mem_addr_q <= {bus.lsu_i_addr[AWIDTH-1:2], 2'b00};
            tmo_q      <= '0;
            if (trap) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              if (is_load(bus.lsu_i_opcode)) rdata_q <= '0;
            end else if (is_load(bus.lsu_i_opcode)) begin
              state_q <= S_READ;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
            end else if (bus.lsu_i_opcode == `STORE) begin
              state_q     <= S_WRITE;
              req_q       <= 1'b1;
              we_q        <= 1'b1;
              mem_wdata_q <= bus.lsu_i_wdata;
            end else begin
              state_q <= S_RMW_RD;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
            end
          end
        end
        S_READ, S_RMW_RD: begin
          if (bus.lsu_i_mem_ack) begin
            tmo_q <= '0;
            if (state_q == S_READ) begin
              req_q   <= 1'b0;
              rdata_q <= load_extend(op_q, lane_q, bus.lsu_i_mem_rdata);
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              we_q        <= 1'b1;
              mem_wdata_q <= store_merge(op_q, lane_q, bus.lsu_i_mem_rdata, store_q);
              state_q     <= S_RMW_WR;
            end
          end else if (tmo_hit) begin
            // Abort; a timed-out RMW read never reaches its write phase
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            if (state_q == S_READ) rdata_q <= '0;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        S_WRITE, S_RMW_WR: begin
          if (bus.lsu_i_mem_ack || tmo_hit) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= !bus.lsu_i_mem_ack;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
